rv_instr_encoder: RTL and testbench
===================================

# rv_instr_encoder

- Inverse of the instruction decode path: takes decoded control fields and a 64-bit immediate, and packs them back into 32-bit RV32I instruction words.
- Writes those words sequentially into instruction memory through a 2-entry output FIFO with a valid/ready write port.
- Sits between the test/boot program loader and the instruction memory of the single-cycle core; it is the only writer of that memory during program load.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width of the instruction-memory write port.
- `FIFO_DEPTH`, default 2: output buffer depth (power of two, ≥2).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse; in IDLE, loads the write pointer from `base_addr` and enters RUN.
- `finish` in 1: pulse; in RUN, enters DRAIN.
- `base_addr` in ADDR_WIDTH: first write address (bits [1:0] ignored, forced 0).
- `in_valid` in 1: descriptor valid.
- `in_ready` out 1: descriptor accepted when `in_valid && in_ready`.
- `in_opcode` in 5: instruction bits [6:2]; legal values 00000 (load), 00100 (op-imm), 01000 (store), 01100 (op), 11000 (branch).
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register fields.
- `in_funct3` in 3: bits [14:12].
- `in_funct7b5` in 1: bit [30] (op and shift-immediate only).
- `in_imm` in 64: sign-extended immediate, same format the decoder's immediate generator produces.
- `wr_valid` out 1: write request.
- `wr_ready` in 1: memory accepts the write.
- `wr_addr` out ADDR_WIDTH: byte address.
- `wr_data` out 32: encoded instruction.
- `done` out 1: one-cycle pulse when DRAIN completes.
- `err` out 1: sticky error flag, cleared by `start`.
- `words_written` out 16: count of words accepted by memory since `start`; saturates at 0xFFFF.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on `finish`; if `start` and `finish` are high together in RUN, `finish` wins.
  - DRAIN → IDLE when the FIFO is empty; `done` is asserted on that transition.
  - `start` is ignored outside IDLE. `finish` is ignored outside RUN.
- `in_ready` = (state == RUN) && (FIFO count < FIFO_DEPTH). The full check uses the registered count; a same-cycle pop does not free a slot.
- Encoding is fixed RV32I with bits [1:0] = 11:
  - R: funct7 = {1'b0, funct7b5, 5'b0}.
  - I: imm[11:0] → [31:20]. For funct3 001/101 in op-imm, [31:25] = {1'b0, funct7b5, 5'b0} and imm[4:0] → [24:20].
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - B: imm[12] → [31], imm[10:5] → [30:25], imm[4:1] → [11:8], imm[11] → [7].
  - Unused register fields are encoded as 0.
- Illegal opcode: the descriptor is consumed but not pushed, and `err` is set.
- Rejected descriptors do not advance the write pointer or `words_written`.
- The write pointer advances by 4 on each `wr_valid && wr_ready`. It wraps modulo 2^ADDR_WIDTH silently.
- `wr_addr` is the pointer value associated with the FIFO head.
- Reset values: state IDLE; `in_ready` 0; `wr_valid` 0; `wr_addr` 0; `wr_data` 0; `done` 0; `err` 0; `words_written` 0; FIFO empty.
- Reset asserted mid-operation discards FIFO contents; no partial write is ever presented.

## Timing
- Descriptor accepted at edge N: the encoded word is registered into the FIFO at N. `wr_valid` is high in the cycle after N if the FIFO was empty.
- `wr_valid`, `wr_addr` and `wr_data` are stable while `wr_valid && !wr_ready`.
- Sustained throughput is 1 word/cycle when `wr_ready` is held at 1.
- `done` is high in the cycle after the final memory handshake in DRAIN. If DRAIN is entered with an empty FIFO, `done` is high in the next cycle.

## Configuration
- `RV_INSTR_ENC_RANGE_CHECK_EN` defined:
  - I/S immediates must satisfy `in_imm[63:11]` all-equal.
  - B immediates must satisfy `in_imm[63:12]` all-equal and `in_imm[0]` == 0.
  - A violation drops the descriptor and sets `err`.
- Undefined: immediates are truncated to the encodable bits without any check; only an illegal opcode sets `err`.

## Structure
- Shared package `rv_isa_pkg` holds:
  - opcode constants: OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_OP, OPC_BRANCH;
  - the FSM state enum;
  - a packed descriptor struct.
- Combinational packing lives in sub-module `rv_instr_pack`: descriptor in → word[31:0] plus a legal flag.
- The FIFO, pointer and FSM are inline in the top module.

## Test plan
- R-type: opcode 01100, rd=3, rs1=1, rs2=2, funct3=000, funct7b5=1, `base_addr`=0x40 → one write, `wr_data`=0x402081B3 at `wr_addr`=0x40.
- I-type: opcode 00100, rd=5, rs1=0, funct3=000, imm=-1 → `wr_data`=0xFFF00293. With the macro defined, imm=0x800 → no write and `err`=1.
- Branch: opcode 11000, rs1=1, rs2=2, funct3=000, imm=-4 → `wr_data`=0xFE208EE3.
- Backpressure: 4 back-to-back descriptors with `wr_ready`=0 → `in_ready` drops after 2. Release `wr_ready` → addresses base, +4, +8, +12 in order; `words_written`=4.
- Drain:
  - `finish` with 2 words buffered, `wr_ready`=1 → two writes, then `done` pulses once and state returns to IDLE.
  - `finish` with an empty FIFO → `done` the next cycle.
- Reset mid-burst: `rst_n` low with 2 words buffered → `wr_valid`=0 immediately and FIFO empty. After release, `start` with `base_addr`=0x3FC and 2 writes → addresses 0x3FC then 0x000 (wrap).

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoder definitions: opcode constants, encoder FSM states,
// the packed decoded-instruction descriptor, and a funct7 helper.
package rv_isa_pkg;

    // Instruction bits [6:2] for the supported RV32I major opcodes
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [63:0] imm;
    } instr_desc_t;

    // funct7 as used by OP and shift-immediate: only bit 30 is variable
    function automatic logic [6:0] funct7_field(input logic b5);
        return {1'b0, b5, 5'b00000};
    endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Descriptor input channel and instruction-memory write channel of the
// encoder. The encoder uses the slave view; the loader/memory side uses master.
interface rv_instr_encoder_if #(
    parameter int ADDR_WIDTH = 10
);
    // descriptor channel (loader -> encoder)
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic                  in_funct7b5;
    logic [63:0]           in_imm;
    // memory write channel (encoder -> instruction memory)
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7b5, in_imm, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7b5, in_imm, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/rv_instr_pack.sv
// Combinational RV32I instruction packer: descriptor in, 32-bit word plus a
// legal flag out. With RV_INSTR_ENC_RANGE_CHECK_EN defined, immediates that
// do not fit their format are flagged illegal; otherwise they are truncated.
module rv_instr_pack
    import rv_isa_pkg::*;
(
    input  instr_desc_t desc,
    output logic [31:0] word,
    output logic        legal
);

    logic is_shift;
    logic unused_imm_hi;

    assign is_shift      = (desc.funct3 == 3'b001) || (desc.funct3 == 3'b101);
    // upper immediate bits only matter to the optional range check
    assign unused_imm_hi = ^desc.imm[63:13];

    // Select the format by opcode and place fields; unused fields stay zero
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (desc.opcode)
            OPC_LOAD: begin
                word = {desc.imm[11:0], desc.rs1, desc.funct3, desc.rd,
                        desc.opcode, 2'b11};
            end
            OPC_OPIMM: begin
                if (is_shift) begin
                    word = {funct7_field(desc.funct7b5), desc.imm[4:0], desc.rs1,
                            desc.funct3, desc.rd, desc.opcode, 2'b11};
                end else begin
                    word = {desc.imm[11:0], desc.rs1, desc.funct3, desc.rd,
                            desc.opcode, 2'b11};
                end
            end
            OPC_STORE: begin
                word = {desc.imm[11:5], desc.rs2, desc.rs1, desc.funct3,
                        desc.imm[4:0], desc.opcode, 2'b11};
            end
            OPC_OP: begin
                word = {funct7_field(desc.funct7b5), desc.rs2, desc.rs1,
                        desc.funct3, desc.rd, desc.opcode, 2'b11};
            end
            OPC_BRANCH: begin
                word = {desc.imm[12], desc.imm[10:5], desc.rs2, desc.rs1,
                        desc.funct3, desc.imm[4:1], desc.imm[11],
                        desc.opcode, 2'b11};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
`ifdef RV_INSTR_ENC_RANGE_CHECK_EN
        // I/S need a 12-bit signed value; B a 13-bit signed even value
        case (desc.opcode)
            OPC_LOAD, OPC_OPIMM, OPC_STORE: begin
                if (!((&desc.imm[63:11]) || !(|desc.imm[63:11]))) begin
                    legal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if (!((&desc.imm[63:12]) || !(|desc.imm[63:12])) || desc.imm[0]) begin
                    legal = 1'b0;
                end
            end
            default: ;
        endcase
`endif
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded instruction descriptors into RV32I words and
// writes them sequentially into instruction memory through a small FIFO.
// Optional feature macro: RV_INSTR_ENC_RANGE_CHECK_EN (immediate range check,
// implemented in rv_instr_pack).
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    rv_instr_encoder_if.slave     bus,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_written
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    enc_state_e            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [31:0]           mem_q [FIFO_DEPTH];
    logic [31:0]           mem_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           ww_q, ww_d;

    instr_desc_t           desc;
    logic [31:0]           enc_word;
    logic                  enc_legal;
    logic                  in_ready;
    logic                  wr_valid;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Gather the descriptor fields from the input channel
    always_comb begin
        desc          = '0;
        desc.opcode   = bus.in_opcode;
        desc.rd       = bus.in_rd;
        desc.rs1      = bus.in_rs1;
        desc.rs2      = bus.in_rs2;
        desc.funct3   = bus.in_funct3;
        desc.funct7b5 = bus.in_funct7b5;
        desc.imm      = bus.in_imm;
    end

    rv_instr_pack u_pack (
        .desc  (desc),
        .word  (enc_word),
        .legal (enc_legal)
    );

    // Full check uses the registered count, so a same-cycle pop never frees a slot
    assign in_ready = (state_q == ST_RUN) && (count_q < CNT_W'(FIFO_DEPTH));
    assign wr_valid = (count_q != '0);
    assign accept   = bus.in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign pop      = wr_valid && bus.wr_ready;

    // FIFO bookkeeping and storage update
    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[tail_q] = enc_word;
        end
    end

    // Next-state logic for the FSM, write pointer, counters and flags
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ww_d    = ww_q;

        if (pop) begin
            ptr_d = ptr_q + ADDR_WIDTH'(4);
            if (ww_q != 16'hFFFF) begin
                ww_d = ww_q + 16'd1;
            end
        end
        if (accept && !enc_legal) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    ptr_d   = {base_addr[ADDR_WIDTH-1:2], 2'b00};
                    err_d   = 1'b0;
                    ww_d    = '0;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // leave as the last word is taken so done follows that handshake
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers; reset empties the FIFO and idles the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ww_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ww_q    <= ww_d;
        end
    end

    // FIFO data storage; contents are only visible while an entry is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_valid  = wr_valid;
    assign bus.wr_addr   = ptr_q;
    assign bus.wr_data   = wr_valid ? mem_q[head_q] : 32'd0;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed cases plus randomized
// descriptors against a field-arithmetic reference encoder and write scoreboard.
module tb_rv_instr_encoder;
    import rv_isa_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          done;
    logic          err;
    logic [15:0]   words_written;

    rv_instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    rv_instr_encoder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .finish        (finish),
        .base_addr     (base_addr),
        .bus           (bus),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder built from the instruction-format bit positions
    function automatic bit ref_enc(input logic [4:0] opc, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic f7,
                                   input logic [63:0] imm_bits,
                                   output logic [31:0] word);
        longint          imm = $signed(imm_bits);
        longint unsigned u   = imm_bits;
        longint unsigned w;
        longint unsigned low = (longint'(opc) << 2) + 3;
        longint unsigned r1  = longint'(rs1) << 15;
        longint unsigned r2  = longint'(rs2) << 20;
        longint unsigned fd  = longint'(f3) << 12;
        longint unsigned dst = longint'(rd) << 7;
        bit in_i = (imm >= -2048) && (imm <= 2047);
        bit in_b = (imm >= -4096) && (imm <= 4095) && ((imm % 2) == 0);
        bit fits;
        bit ok = 1'b1;
        w    = 0;
        fits = 1'b1;
        case (opc)
            5'b00000: begin w = ((u % 4096) << 20) + r1 + fd + dst + low; fits = in_i; end
            5'b00100: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    w = (longint'(f7) << 30) + ((u % 32) << 20) + r1 + fd + dst + low;
                else
                    w = ((u % 4096) << 20) + r1 + fd + dst + low;
                fits = in_i;
            end
            5'b01000: begin
                w = (((u >> 5) % 128) << 25) + r2 + r1 + fd + ((u % 32) << 7) + low;
                fits = in_i;
            end
            5'b01100: begin w = (longint'(f7) << 30) + r2 + r1 + fd + dst + low; end
            5'b11000: begin
                w = (((u >> 12) % 2) << 31) + (((u >> 5) % 64) << 25) + r2 + r1 + fd
                    + (((u >> 1) % 16) << 8) + (((u >> 11) % 2) << 7) + low;
                fits = in_b;
            end
            default: ok = 1'b0;
        endcase
`ifdef RV_INSTR_ENC_RANGE_CHECK_EN
        if (!fits) ok = 1'b0;
`else
        if (!fits) ok = ok;
`endif
        word = w[31:0];
        return ok;
    endfunction

    // Scoreboard state, owned by the monitor
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_ptr = '0;
    int            exp_ww = 0;
    bit            exp_err = 1'b0;
    int            n_writes = 0;
    logic [31:0]   last_data = '0;
    logic [AW-1:0] last_addr = '0;
    bit            stall_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    logic [31:0]   stall_data = '0;

    bit rdy_rand  = 1'b0;
    bit rdy_fixed = 1'b1;

    // Memory-side ready generator
    always @(posedge clk) begin
        #2;
        bus.wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor: checks writes, holds under stall, and models accepted descriptors
    always @(negedge clk) begin
        logic [31:0] w;
        bit ok;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
            exp_ptr    = '0;
            exp_ww     = 0;
            exp_err    = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", bus.wr_valid, 1);
                chk("hold_addr", bus.wr_addr, stall_addr);
                chk("hold_data", bus.wr_data, stall_data);
            end
            if (bus.wr_valid && bus.wr_ready) begin
                chk("wr_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("wr_data", bus.wr_data, exp_q.pop_front());
                chk("wr_addr", bus.wr_addr, exp_ptr);
                last_data = bus.wr_data;
                last_addr = bus.wr_addr;
                exp_ptr   = exp_ptr + AW'(4);
                if (exp_ww < 65535) exp_ww++;
                n_writes++;
            end
            stall_prev = bus.wr_valid && !bus.wr_ready;
            stall_addr = bus.wr_addr;
            stall_data = bus.wr_data;
            if (bus.in_valid && bus.in_ready) begin
                ok = ref_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                             bus.in_funct3, bus.in_funct7b5, bus.in_imm, w);
                if (ok) exp_q.push_back(w);
                else exp_err = 1'b1;
            end
            if (start) begin
                exp_ptr = {base_addr[AW-1:2], 2'b00};
                exp_err = 1'b0;
                exp_ww  = 0;
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] base);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic do_finish();
        @(posedge clk); #1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic drive(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                         input logic [63:0] imm);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = opc;
        bus.in_rd       = rd;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_imm      = imm;
    endtask

    task automatic send(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [63:0] imm);
        bit seen = 1'b0;
        @(posedge clk); #1;
        drive(opc, rd, rs1, rs2, f3, f7, imm);
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = bus.in_ready;
        end
        chk("send_accept", seen, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        for (int k = 0; k < 300 && n_writes < target; k++) @(negedge clk);
        chk("write_wait", n_writes >= target, 1);
    endtask

    task automatic wait_done(input int limit, output int pulses);
        pulses = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int pulses;
        logic [4:0]  opcs [5];
        logic [4:0]  r_opc;
        logic [63:0] r_imm;
        opcs[0] = OPC_LOAD; opcs[1] = OPC_OPIMM; opcs[2] = OPC_STORE;
        opcs[3] = OPC_OP;   opcs[4] = OPC_BRANCH;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 64'd0);
        bus.in_valid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_written, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 0);

        // R-type, I-type, immediate edge, branch
        do_start(10'h40);
        w0 = n_writes;
        send(OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 64'd0);
        wait_writes(w0 + 1);
        chk("r_data", last_data, 32'h402081B3);
        chk("r_addr", last_addr, 10'h40);
        send(OPC_OPIMM, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_writes(w0 + 2);
        chk("i_data", last_data, 32'hFFF00293);
        send(OPC_OPIMM, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 64'h800);
`ifdef RV_INSTR_ENC_RANGE_CHECK_EN
        repeat (4) @(negedge clk);
        chk("i_range_err", err, 1);
        chk("i_range_nowrite", n_writes, w0 + 2);
        w0 = w0 - 1;
`else
        wait_writes(w0 + 3);
        chk("i_trunc_data", last_data, 32'h80000293);
        chk("i_trunc_err", err, 0);
`endif
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_writes(w0 + 4);
        chk("b_data", last_data, 32'hFE208EE3);

        // illegal opcode consumed, no write, pointer unchanged
        w0 = n_writes;
        send(5'b00001, 5'd7, 5'd7, 5'd7, 3'd0, 1'b0, 64'd5);
        repeat (3) @(negedge clk);
        chk("illegal_err", err, 1);
        chk("illegal_nowrite", n_writes, w0);
        send(OPC_LOAD, 5'd9, 5'd2, 5'd0, 3'd2, 1'b0, 64'd16);
        wait_writes(w0 + 1);
        chk("illegal_words", words_written, exp_ww);

        // finish with an empty FIFO
        do_finish();
        @(negedge clk);
        chk("drain_empty_d0", done, 0);
        @(negedge clk);
        chk("drain_empty_d1", done, 1);
        @(negedge clk);
        chk("drain_empty_d2", done, 0);

        // backpressure: two slots, then release
        @(posedge clk); #1;
        rdy_fixed = 1'b0;
        do_start(10'h100);
        w0 = n_writes;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(OPC_OP, 5'(i + 1), 5'(i + 2), 5'(i + 3), 3'(i), i[0], 64'd0);
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, (i < 2) ? 1 : 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rdy_fixed = 1'b1;
        send(OPC_OP, 5'd3, 5'd4, 5'd5, 3'd2, 1'b0, 64'd0);
        send(OPC_OP, 5'd4, 5'd5, 5'd6, 3'd3, 1'b1, 64'd0);
        wait_writes(w0 + 4);
        chk("bp_last_addr", last_addr, 10'h10C);
        chk("bp_words", words_written, 4);

        // drain with two words buffered
        @(posedge clk); #1;
        rdy_fixed = 1'b0;
        send(OPC_STORE, 5'd0, 5'd3, 5'd4, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
        send(OPC_LOAD, 5'd6, 5'd3, 5'd0, 3'd2, 1'b0, 64'd12);
        w0 = n_writes;
        rdy_fixed = 1'b1;
        do_finish();
        wait_done(10, pulses);
        chk("drain_done_pulses", pulses, 1);
        chk("drain_writes", n_writes, w0 + 2);
        chk("drain_idle", bus.in_ready, 0);
        chk("drain_words", words_written, 6);

        // reset mid-burst, then pointer wrap
        @(posedge clk); #1;
        rdy_fixed = 1'b0;
        do_start(10'h200);
        send(OPC_OP, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 64'd0);
        send(OPC_OP, 5'd2, 5'd3, 5'd4, 3'd0, 1'b1, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_valid", bus.wr_valid, 0);
        chk("mid_rst_wr_data", bus.wr_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_fixed = 1'b1;
        w0 = n_writes;
        repeat (4) @(negedge clk);
        chk("post_rst_empty", n_writes, w0);
        chk("post_rst_words", words_written, 0);
        do_start(10'h3FC);
        send(OPC_OPIMM, 5'd8, 5'd9, 5'd0, 3'd1, 1'b1, 64'd7);
        send(OPC_OPIMM, 5'd8, 5'd9, 5'd0, 3'd5, 1'b1, 64'd31);
        wait_writes(w0 + 2);
        chk("wrap_last_addr", last_addr, 10'h000);
        do_finish();
        wait_done(6, pulses);
        chk("wrap_done_pulses", pulses, 1);

        // randomized descriptors under random backpressure
        rdy_rand = 1'b1;
        do_start(AW'($urandom_range(0, 1023)));
        for (int n = 0; n < 80; n++) begin
            r_opc = ($urandom_range(0, 9) == 0) ? 5'($urandom) : opcs[$urandom_range(0, 4)];
            case ($urandom_range(0, 3))
                0: r_imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
                1: r_imm = 64'(longint'($urandom_range(0, 4095)) * 2 - 4096);
                2: r_imm = {$urandom, $urandom};
                default: r_imm = ($urandom_range(0, 1) != 0) ? 64'h800 : 64'hFFFF_FFFF_FFFF_F7FF;
            endcase
            send(r_opc, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 1'($urandom), r_imm);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        do_finish();
        for (int k = 0; k < 500 && !done; k++) @(negedge clk);
        chk("rand_done", done, 1);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_words", words_written, exp_ww);
        chk("rand_err", err, exp_err);
        rdy_rand = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
